// File: rtl/alu_z_stage_if.sv
// alu_z_stage_if: ALU result / Z-register bus bundle between control, ALU and Z stage.
// master = control/ALU side driving results and requests; slave = the Z stage.
// Pure wiring; no timing of its own.
interface alu_z_stage_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] alu_lo;
  logic [DATA_W-1:0] alu_hi;
  logic              alu_valid;
  logic              z_in;
  logic              zlo_out;
  logic              zhi_out;
  logic [DATA_W-1:0] bus_out;
  logic              z_busy;
  logic              z_ready;
  logic              flag_zero;
  logic              flag_neg;
  logic              drive_conflict;
  logic              timeout_err;

  modport master (
    output alu_lo, alu_hi, alu_valid, z_in, zlo_out, zhi_out,
    input  bus_out, z_busy, z_ready, flag_zero, flag_neg, drive_conflict, timeout_err
  );

  modport slave (
    input  alu_lo, alu_hi, alu_valid, z_in, zlo_out, zhi_out,
    output bus_out, z_busy, z_ready, flag_zero, flag_neg, drive_conflict, timeout_err
  );
endinterface

// File: rtl/alu_z_stage.sv
// alu_z_stage: captures ALU lo/hi results into ZLO/ZHI with registered zero/neg flags.
// Latency: 1 cycle from accepted z_in + alu_valid to z_ready; bus drive is combinational.
// Backpressure: a request without alu_valid parks in WAIT (z_busy) until the result arrives.
// Optional macro ALU_Z_STAGE_TIMEOUT_EN abandons WAIT after TIMEOUT cycles and sets timeout_err.
module alu_z_stage #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input logic          clk,
  input logic          clr,
  alu_z_stage_if.slave zif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } state_t;

  // The wait counter must be able to reach TIMEOUT-1, so TIMEOUT below 2 is meaningless.
  if (TIMEOUT < 2) begin : g_timeout_check
    $error("alu_z_stage: TIMEOUT must be at least 2");
  end

  state_t            state_q, state_d;
  logic [DATA_W-1:0] zlo_q, zlo_d;
  logic [DATA_W-1:0] zhi_q, zhi_d;
  logic              fzero_q, fzero_d;
  logic              fneg_q, fneg_d;

`ifdef ALU_Z_STAGE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             terr_q, terr_d;
`endif

  // Next-state and capture decision; a capture always loads Z and both flags together.
  always_comb begin
    state_d = state_q;
    zlo_d   = zlo_q;
    zhi_d   = zhi_q;
    fzero_d = fzero_q;
    fneg_d  = fneg_q;
`ifdef ALU_Z_STAGE_TIMEOUT_EN
    cnt_d   = cnt_q;
    terr_d  = terr_q;
`endif
    case (state_q)
      IDLE, HOLD: begin
        if (zif.z_in) begin
`ifdef ALU_Z_STAGE_TIMEOUT_EN
          terr_d = 1'b0;
`endif
          if (zif.alu_valid) begin
            zlo_d   = zif.alu_lo;
            zhi_d   = zif.alu_hi;
            fzero_d = (zif.alu_lo == '0);
            fneg_d  = zif.alu_lo[DATA_W-1];
            state_d = HOLD;
          end else begin
            state_d = WAIT;
`ifdef ALU_Z_STAGE_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end
        end
      end
      WAIT: begin
        // z_in is deliberately ignored here: the pending request already owns the stage.
        if (zif.alu_valid) begin
          zlo_d   = zif.alu_lo;
          zhi_d   = zif.alu_hi;
          fzero_d = (zif.alu_lo == '0);
          fneg_d  = zif.alu_lo[DATA_W-1];
          state_d = HOLD;
        end
`ifdef ALU_Z_STAGE_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = IDLE;
          terr_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // State, Z pair and flags; clr discards any pending capture immediately.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      zlo_q   <= '0;
      zhi_q   <= '0;
      fzero_q <= 1'b0;
      fneg_q  <= 1'b0;
`ifdef ALU_Z_STAGE_TIMEOUT_EN
      cnt_q   <= '0;
      terr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      zlo_q   <= zlo_d;
      zhi_q   <= zhi_d;
      fzero_q <= fzero_d;
      fneg_q  <= fneg_d;
`ifdef ALU_Z_STAGE_TIMEOUT_EN
      cnt_q   <= cnt_d;
      terr_q  <= terr_d;
`endif
    end
  end

  // Bus drive reads the registers only, so a capture-cycle read sees the old Z; ZLO wins a conflict.
  always_comb begin
    if (zif.zlo_out)      zif.bus_out = zlo_q;
    else if (zif.zhi_out) zif.bus_out = zhi_q;
    else                  zif.bus_out = '0;
  end

  assign zif.drive_conflict = zif.zlo_out & zif.zhi_out;
  assign zif.z_busy         = (state_q == WAIT);
  assign zif.z_ready        = (state_q == HOLD);
  assign zif.flag_zero      = fzero_q;
  assign zif.flag_neg       = fneg_q;
`ifdef ALU_Z_STAGE_TIMEOUT_EN
  assign zif.timeout_err    = terr_q;
`else
  assign zif.timeout_err    = 1'b0;
`endif

endmodule

// File: tb/tb_alu_z_stage.sv
// Directed bench for alu_z_stage: inputs change on the falling edge, outputs are checked
// on the falling edge or shortly after a rising edge, never at the active edge itself.
module tb_alu_z_stage;
  localparam int DATA_W = 32;
  localparam int TMO    = 8;

  logic clk;
  logic clr;
  int   n_checks;
  int   n_errors;

  alu_z_stage_if #(.DATA_W(DATA_W)) zif ();

  alu_z_stage #(.DATA_W(DATA_W), .TIMEOUT(TMO)) dut (
    .clk (clk),
    .clr (clr),
    .zif (zif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends on its own.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    zif.alu_lo    = '0;
    zif.alu_hi    = '0;
    zif.alu_valid = 1'b0;
    zif.z_in      = 1'b0;
    zif.zlo_out   = 1'b0;
    zif.zhi_out   = 1'b0;
  endtask

  // One-cycle capture of lo/hi, returning at the falling edge after the capture edge.
  task automatic capture(input logic [31:0] lo, input logic [31:0] hi);
    @(negedge clk);
    zif.alu_lo = lo; zif.alu_hi = hi; zif.alu_valid = 1'b1; zif.z_in = 1'b1;
    @(negedge clk);
    zif.z_in = 1'b0; zif.alu_valid = 1'b0;
  endtask

  task automatic test_reset();
    clr = 1'b1;
    idle_inputs();
    @(negedge clk);
    zif.zlo_out = 1'b1;
    #1;
    n_checks++; if (zif.bus_out !== 32'h0) begin n_errors++; $display("FAIL reset_bus: got %h want 00000000", zif.bus_out); end
    n_checks++; if ({zif.z_busy, zif.z_ready, zif.flag_zero, zif.flag_neg, zif.timeout_err} !== 5'b0) begin
      n_errors++; $display("FAIL reset_flags: got %b want 00000", {zif.z_busy, zif.z_ready, zif.flag_zero, zif.flag_neg, zif.timeout_err}); end
    zif.zlo_out = 1'b0;
    clr = 1'b0;
    capture(32'h12345678, 32'h0);
    zif.zlo_out = 1'b1;
    #1;
    n_checks++; if (zif.bus_out !== 32'h12345678) begin n_errors++; $display("FAIL pre_reset_capture: got %h want 12345678", zif.bus_out); end
    #1 clr = 1'b1;
    #1;
    n_checks++; if (zif.bus_out !== 32'h0) begin n_errors++; $display("FAIL async_reset_bus: got %h want 00000000", zif.bus_out); end
    n_checks++; if (zif.z_ready !== 1'b0) begin n_errors++; $display("FAIL async_reset_ready: got %b want 0", zif.z_ready); end
    @(negedge clk);
    clr = 1'b0;
    zif.zlo_out = 1'b0;
  endtask

  task automatic test_rotate();
    capture(32'h80000001, 32'h0);
    n_checks++; if (zif.z_ready !== 1'b1) begin n_errors++; $display("FAIL rot_ready: got %b want 1", zif.z_ready); end
    n_checks++; if ({zif.flag_neg, zif.flag_zero} !== 2'b10) begin n_errors++; $display("FAIL rot_flags: got %b want 10", {zif.flag_neg, zif.flag_zero}); end
    zif.zlo_out = 1'b1;
    #1;
    n_checks++; if (zif.bus_out !== 32'h80000001) begin n_errors++; $display("FAIL rot_bus: got %h want 80000001", zif.bus_out); end
    zif.zlo_out = 1'b0;
  endtask

  task automatic test_mul_wait();
    @(negedge clk);
    zif.z_in = 1'b1; zif.alu_valid = 1'b0;
    @(negedge clk);
    zif.z_in = 1'b0;
    zif.zlo_out = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++; if (zif.z_busy !== 1'b1 || zif.z_ready !== 1'b0) begin
        n_errors++; $display("FAIL mul_busy_%0d: got busy=%b ready=%b want busy=1 ready=0", i, zif.z_busy, zif.z_ready); end
      if (i == 0) begin
        n_checks++; if (zif.bus_out !== 32'h80000001) begin n_errors++; $display("FAIL wait_stale_bus: got %h want 80000001", zif.bus_out); end
        zif.zlo_out = 1'b0;
        zif.z_in = 1'b1;   // ignored while waiting
      end
      if (i == 4) begin
        zif.z_in = 1'b0;
        zif.alu_valid = 1'b1; zif.alu_lo = 32'h0; zif.alu_hi = 32'h00000001;
      end
      @(negedge clk);
    end
    zif.alu_valid = 1'b0; zif.alu_lo = 32'hDEADBEEF; zif.alu_hi = 32'hDEADBEEF;
    n_checks++; if (zif.z_busy !== 1'b0 || zif.z_ready !== 1'b1) begin
      n_errors++; $display("FAIL mul_done: got busy=%b ready=%b want busy=0 ready=1", zif.z_busy, zif.z_ready); end
    n_checks++; if ({zif.flag_zero, zif.flag_neg} !== 2'b10) begin n_errors++; $display("FAIL mul_flags: got %b want 10", {zif.flag_zero, zif.flag_neg}); end
    zif.zhi_out = 1'b1;
    #1;
    n_checks++; if (zif.bus_out !== 32'h00000001) begin n_errors++; $display("FAIL mul_hi: got %h want 00000001", zif.bus_out); end
    zif.zhi_out = 1'b0; zif.zlo_out = 1'b1;
    #1;
    n_checks++; if (zif.bus_out !== 32'h00000000) begin n_errors++; $display("FAIL mul_lo: got %h want 00000000", zif.bus_out); end
    zif.zlo_out = 1'b0;
  endtask

  task automatic test_conflict();
    capture(32'hAAAA5555, 32'h0F0F0F0F);
    zif.zlo_out = 1'b1; zif.zhi_out = 1'b1;
    #1;
    n_checks++; if (zif.bus_out !== 32'hAAAA5555 || zif.drive_conflict !== 1'b1) begin
      n_errors++; $display("FAIL conflict_both: got bus=%h conf=%b want AAAA5555 1", zif.bus_out, zif.drive_conflict); end
    zif.zlo_out = 1'b0;
    #1;
    n_checks++; if (zif.bus_out !== 32'h0F0F0F0F || zif.drive_conflict !== 1'b0) begin
      n_errors++; $display("FAIL conflict_hi: got bus=%h conf=%b want 0F0F0F0F 0", zif.bus_out, zif.drive_conflict); end
    zif.zhi_out = 1'b0;
    #1;
    n_checks++; if (zif.bus_out !== 32'h0) begin n_errors++; $display("FAIL no_drive: got %h want 00000000", zif.bus_out); end
    n_checks++; if (zif.flag_neg !== 1'b1) begin n_errors++; $display("FAIL conflict_neg: got %b want 1", zif.flag_neg); end
  endtask

  task automatic test_back_to_back();
    capture(32'h00000007, 32'h0);
    // Held indefinitely in HOLD while z_in stays low, even with valid data present.
    zif.alu_valid = 1'b1; zif.alu_lo = 32'h12121212;
    repeat (3) @(negedge clk);
    zif.zlo_out = 1'b1;
    #1;
    n_checks++; if (zif.bus_out !== 32'h00000007 || zif.z_ready !== 1'b1) begin
      n_errors++; $display("FAIL hold_value: got bus=%h ready=%b want 00000007 1", zif.bus_out, zif.z_ready); end
    zif.z_in = 1'b1; zif.alu_lo = 32'hFFFFFFFF; zif.alu_hi = 32'h0;
    #1;
    n_checks++; if (zif.bus_out !== 32'h00000007) begin n_errors++; $display("FAIL capture_cycle_read: got %h want 00000007", zif.bus_out); end
    @(posedge clk);
    #1;
    n_checks++; if (zif.bus_out !== 32'hFFFFFFFF || zif.flag_neg !== 1'b1) begin
      n_errors++; $display("FAIL b2b_new: got bus=%h neg=%b want FFFFFFFF 1", zif.bus_out, zif.flag_neg); end
    @(negedge clk);
    zif.z_in = 1'b0; zif.alu_valid = 1'b0; zif.zlo_out = 1'b0;
  endtask

  task automatic test_timeout();
    @(negedge clk);
    zif.z_in = 1'b1; zif.alu_valid = 1'b0;
    @(negedge clk);
    zif.z_in = 1'b0;
`ifdef ALU_Z_STAGE_TIMEOUT_EN
    for (int i = 0; i < TMO; i++) begin
      n_checks++; if (zif.z_busy !== 1'b1) begin n_errors++; $display("FAIL tmo_busy_%0d: got %b want 1", i, zif.z_busy); end
      @(negedge clk);
    end
    zif.zlo_out = 1'b1;
    #1;
    n_checks++; if (zif.z_busy !== 1'b0 || zif.timeout_err !== 1'b1 || zif.z_ready !== 1'b0) begin
      n_errors++; $display("FAIL tmo_expire: got busy=%b err=%b ready=%b want 0 1 0", zif.z_busy, zif.timeout_err, zif.z_ready); end
    n_checks++; if (zif.bus_out !== 32'hFFFFFFFF) begin n_errors++; $display("FAIL tmo_z_kept: got %h want FFFFFFFF", zif.bus_out); end
    zif.zlo_out = 1'b0;
    capture(32'h00000003, 32'h0);
    n_checks++; if (zif.timeout_err !== 1'b0 || zif.z_ready !== 1'b1) begin
      n_errors++; $display("FAIL tmo_clear: got err=%b ready=%b want 0 1", zif.timeout_err, zif.z_ready); end
`else
    repeat (100) @(negedge clk);
    n_checks++; if (zif.z_busy !== 1'b1 || zif.timeout_err !== 1'b0) begin
      n_errors++; $display("FAIL no_timeout: got busy=%b err=%b want 1 0", zif.z_busy, zif.timeout_err); end
    // Reset mid-WAIT discards the pending request.
    clr = 1'b1;
    #1;
    n_checks++; if (zif.z_busy !== 1'b0) begin n_errors++; $display("FAIL reset_in_wait: got busy=%b want 0", zif.z_busy); end
    zif.alu_valid = 1'b1; zif.alu_lo = 32'h55555555;
    @(negedge clk);
    clr = 1'b0;
    zif.alu_valid = 1'b0;
    @(negedge clk);
    zif.zlo_out = 1'b1;
    #1;
    n_checks++; if (zif.bus_out !== 32'h0 || zif.z_ready !== 1'b0) begin
      n_errors++; $display("FAIL wait_discard: got bus=%h ready=%b want 00000000 0", zif.bus_out, zif.z_ready); end
    zif.zlo_out = 1'b0;
`endif
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    test_reset();
    test_rotate();
    test_mul_wait();
    test_conflict();
    test_back_to_back();
    test_timeout();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/alu_z_stage.md
Name: alu_z_stage

Overview:
- ALU result-capture stage directly downstream of the shift/rotate/arith datapath. It latches ALU outputs into the Z register pair (ZLO/ZHI) and drives them onto the internal bus on request.
- Handles both single-cycle results (rotate, shift, logic, add) and multi-cycle results (mul/div) through a capture handshake.
- Produces registered zero/negative flags for the control unit.

Parameters:
- DATA_W, 32, width of each half of Z and of the bus
- TIMEOUT, 64, max cycles spent waiting for alu_valid; used only with the optional feature

Ports:
- clk  in  1  system clock; all state updates on rising edge
- clr  in  1  reset, asynchronous, active-high
- alu_lo  in  DATA_W  ALU low result; rotate/shift/logic/add result, mul low word, div quotient
- alu_hi  in  DATA_W  ALU high result; mul high word, div remainder; 0 for single-cycle ops
- alu_valid  in  1  alu_lo/alu_hi valid this cycle; tied high for single-cycle ops, pulses at mul/div completion
- z_in  in  1  control request to capture the next valid ALU result
- zlo_out  in  1  drive ZLO onto bus_out
- zhi_out  in  1  drive ZHI onto bus_out
- bus_out  out  DATA_W  bus drive value
- z_busy  out  1  stage is waiting for a multi-cycle result
- z_ready  out  1  Z holds a completed capture
- flag_zero  out  1  registered: captured ZLO == 0
- flag_neg  out  1  registered: captured ZLO[DATA_W-1]
- drive_conflict  out  1  combinational: zlo_out and zhi_out both high
- timeout_err  out  1  sticky timeout indication; always 0 without the optional feature

Behaviour:
- Clock and reset: one clock, clk. Reset clr is asynchronous and active-high.
- Reset state: ZLO=0, ZHI=0, state=IDLE, z_busy=0, z_ready=0, flag_zero=0, flag_neg=0, timeout_err=0, wait counter=0. bus_out=0 while no drive enable is asserted.
- States: IDLE, WAIT, HOLD.
- IDLE or HOLD, z_in=1 and alu_valid=1:
  - At the edge: ZLO<=alu_lo, ZHI<=alu_hi, flags updated from alu_lo, state<=HOLD.
  - z_ready=1 from the next cycle. Capture latency is 1 cycle.
- IDLE or HOLD, z_in=1 and alu_valid=0:
  - state<=WAIT, z_busy=1, z_ready=0, counter<=0.
  - ZLO, ZHI and flags keep their old values.
- WAIT:
  - z_in is ignored; the pending request is held.
  - On alu_valid=1: capture as above, state<=HOLD, z_busy<=0, z_ready<=1.
- HOLD, z_in=0: all values held indefinitely. Repeated bus reads are allowed.
- z_in=0 in IDLE: no change.
- Bus drive is combinational from registers:
  - zlo_out only: bus_out=ZLO
  - zhi_out only: bus_out=ZHI
  - neither: bus_out=0
  - both: bus_out=ZLO and drive_conflict=1
- Driving in WAIT returns the stale previous Z. This is legal; control must not rely on it.
- Capture-edge precedence: a drive request in the capture cycle returns the pre-capture value; the new value is visible the next cycle.
- Flags are computed from alu_lo only, regardless of alu_hi.
- Reset asserted mid-WAIT or mid-HOLD: immediate return to the reset state; any pending capture is discarded.
- No arithmetic is performed; values are passed through bit-exact at DATA_W.

Optional Feature:
- Macro: ALU_Z_STAGE_TIMEOUT_EN.
- Defined:
  - In WAIT the counter increments each cycle that alu_valid=0.
  - When the counter reaches TIMEOUT-1 with alu_valid still 0: state<=IDLE, z_busy<=0, timeout_err<=1, Z unchanged.
  - timeout_err is sticky; it clears on the next accepted z_in or on clr.
  - alu_valid arriving in the same cycle as expiry wins: capture occurs and no error is raised.
- Undefined: WAIT persists until alu_valid or clr. No counter logic; timeout_err is tied 0.

Test Plan:
- Reset: assert clr mid-cycle with Z=0x12345678 -> all outputs 0 immediately, state IDLE, bus_out=0 with zlo_out=1.
- Single-cycle rotate: alu_lo=0x80000001 (0xC0000000 rotated left by 1), alu_valid=1, z_in=1 for 1 cycle -> next cycle z_ready=1, flag_neg=1, flag_zero=0; zlo_out=1 gives bus_out=0x80000001.
- Multi-cycle mul: z_in=1 with alu_valid=0, then alu_valid pulses 5 cycles later with hi=0x00000001, lo=0x00000000 -> z_busy=1 for 5 cycles; afterwards z_ready=1, flag_zero=1; zhi_out gives 0x00000001, zlo_out gives 0x00000000.
- Drive conflict: Z=lo 0xAAAA5555 / hi 0x0F0F0F0F, zlo_out=zhi_out=1 -> bus_out=0xAAAA5555, drive_conflict=1. Deassert zlo_out -> bus_out=0x0F0F0F0F, drive_conflict=0.
- Back-to-back capture: HOLD with 0x00000007, then z_in=1 with alu_lo=0xFFFFFFFF valid -> next cycle ZLO=0xFFFFFFFF, flag_neg=1. A read in the capture cycle returns 0x00000007.
- Timeout (with ALU_Z_STAGE_TIMEOUT_EN, TIMEOUT=8): z_in=1, alu_valid held 0 -> after 8 cycles state IDLE, timeout_err=1, Z unchanged. Next valid z_in clears timeout_err. Without the macro, 100 cycles later z_busy=1 still.
